// File: rtl/fetch_decode_if.sv
// Bundles the fetch/decode stage's memory, EX feedback, IF/ID field and hazard signals.
// master = the stage itself, slave = the surrounding pipeline / memory.
interface fetch_decode_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic             ex_mem2reg;
  logic [4:0]       ex_rt;
  logic             br_taken;
  logic [31:0]      br_target;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [15:0]      imm;
  logic [31:0]      pc_plus4;
  logic             id_valid;
  logic             Stall;
  logic             flush_id;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       fsm_state;

  modport master (
    input  imem_data, ex_mem2reg, ex_rt, br_taken, br_target,
    output imem_addr, opcode, funct, rs, rt, rd, imm, pc_plus4,
           id_valid, Stall, flush_id, stall_cnt, fsm_state
  );

  modport slave (
    output imem_data, ex_mem2reg, ex_rt, br_taken, br_target,
    input  imem_addr, opcode, funct, rs, rt, rd, imm, pc_plus4,
           id_valid, Stall, flush_id, stall_cnt, fsm_state
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// IF stage with IF/ID register: PC ownership, field split, load-use stall detection,
// and redirect on jump (decoded in ID) or taken branch (resolved in EX).
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic            CLK,
  input  logic            RST,
  fetch_decode_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic [31:0]      pp4_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] pc_next_seq;
  logic [31:0] jump_target;
  logic        jump;
  logic        stall;
  logic        flush;
  logic        rs_hit;
  logic        rt_hit;

  assign pc_next_seq = pc_q + 32'd4;
  assign jump_target = {pp4_q[31:28], instr_q[25:0], 2'b00};
  assign jump        = valid_q && (instr_q[31:26] == 6'h02);
  assign rs_hit      = (bus.ex_rt == instr_q[25:21]);
  assign rt_hit      = (bus.ex_rt == instr_q[20:16]);

  // id_valid=0 marks a bubble: a bubble never stalls or jumps. Stall holds PC and
  // IF/ID for the cycle it is high; a taken branch always overrides it.
  assign stall = !RST && (state_q == RUN) && valid_q && bus.ex_mem2reg &&
                 (bus.ex_rt != 5'd0) && (rs_hit || rt_hit) && !bus.br_taken;
  assign flush = !RST && bus.br_taken;

  always_comb begin
    state_d = state_q;
    if (bus.br_taken)  state_d = FLUSH;
    else if (stall)    state_d = state_q;
    else if (jump)     state_d = FLUSH;
    else               state_d = RUN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pp4_q   <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (bus.br_taken) begin
        pc_q    <= bus.br_target;
        instr_q <= 32'h0;
        valid_q <= 1'b0;
      end else if (stall) begin
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end else if (jump) begin
        pc_q    <= jump_target;
        instr_q <= 32'h0;
        valid_q <= 1'b0;
      end else begin
        pc_q    <= pc_next_seq;
        instr_q <= bus.imem_data;
        pp4_q   <= pc_next_seq;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.opcode    = instr_q[31:26];
  assign bus.funct     = instr_q[5:0];
  assign bus.rs        = instr_q[25:21];
  assign bus.rt        = instr_q[20:16];
  assign bus.rd        = instr_q[15:11];
  assign bus.imm       = instr_q[15:0];
  assign bus.pc_plus4  = pp4_q;
  assign bus.id_valid  = valid_q;
  assign bus.Stall     = stall;
  assign bus.flush_id  = flush;
  assign bus.stall_cnt = cnt_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: free-run fetch, load-use stall, jump,
// branch priority, PC wrap, stall counter saturation and reset during FLUSH.
module tb_fetch_decode_stage;

  localparam int CNT_W = 2;

  logic        clk;
  logic        rst;
  logic        ovr_en;
  logic [31:0] ovr_word;
  int          total;
  int          bad;

  fetch_decode_if #(.CNT_W(CNT_W)) bus ();

  fetch_decode_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Combinational instruction memory: word = addr | 0x2000_0000 unless overridden.
  assign bus.imem_data = ovr_en ? ovr_word : (bus.imem_addr | 32'h2000_0000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ovr_en = 1'b0;
    ovr_word = 32'h0;
    bus.ex_mem2reg = 1'b0;
    bus.ex_rt      = 5'd0;
    bus.br_taken   = 1'b0;
    bus.br_target  = 32'h0;

    // Reset state
    step(); step();
    check("rst_pc",     bus.imem_addr, 32'h0);
    check("rst_valid",  32'(bus.id_valid), 32'd0);
    check("rst_opcode", 32'(bus.opcode), 32'd0);
    check("rst_pp4",    bus.pc_plus4, 32'h0);
    check("rst_cnt",    32'(bus.stall_cnt), 32'd0);
    check("rst_state",  32'(bus.fsm_state), 32'd0);
    bus.br_taken = 1'b1;
    #1;
    check("rst_flush_masked", 32'(bus.flush_id), 32'd0);
    check("rst_stall_masked", 32'(bus.Stall), 32'd0);
    bus.br_taken = 1'b0;
    rst = 1'b0;

    // Free-run fetch
    step();
    check("run_pc1",    bus.imem_addr, 32'h4);
    check("run_state",  32'(bus.fsm_state), 32'd1);
    check("run_valid",  32'(bus.id_valid), 32'd1);
    check("run_opcode", 32'(bus.opcode), 32'd8);
    check("run_pp4a",   bus.pc_plus4, 32'h4);
    step();
    check("run_pc2",    bus.imem_addr, 32'h8);
    check("run_imm",    32'(bus.imm), 32'h0004);
    check("run_pp4b",   bus.pc_plus4, 32'h8);

    // add $3,$5,$6 into ID
    ovr_en = 1'b1; ovr_word = 32'h00A6_1820;
    step();
    ovr_en = 1'b0;
    check("add_rs",    32'(bus.rs), 32'd5);
    check("add_rt",    32'(bus.rt), 32'd6);
    check("add_rd",    32'(bus.rd), 32'd3);
    check("add_funct", 32'(bus.funct), 32'h20);
    check("add_pc",    bus.imem_addr, 32'hC);

    // Load-use on rs
    bus.ex_mem2reg = 1'b1; bus.ex_rt = 5'd5;
    #1;
    check("lu_stall", 32'(bus.Stall), 32'd1);
    step();
    check("lu_pc_held",  bus.imem_addr, 32'hC);
    check("lu_funct",    32'(bus.funct), 32'h20);
    check("lu_pp4_held", bus.pc_plus4, 32'hC);
    check("lu_cnt",      32'(bus.stall_cnt), 32'd1);
    bus.ex_rt = 5'd7;
    #1;
    check("nohit_stall", 32'(bus.Stall), 32'd0);
    bus.ex_rt = 5'd6;
    #1;
    check("rt_hit_stall", 32'(bus.Stall), 32'd1);
    bus.ex_rt = 5'd0;
    #1;
    check("zero_stall", 32'(bus.Stall), 32'd0);
    step();
    check("zero_pc_adv", bus.imem_addr, 32'h10);
    check("zero_imm",    32'(bus.imm), 32'h000C);
    check("zero_cnt",    32'(bus.stall_cnt), 32'd1);

    // Jump with rs=5 in ID while load-use: stall wins; counter saturates
    bus.ex_mem2reg = 1'b0;
    ovr_en = 1'b1; ovr_word = 32'h08A0_0040;
    step();
    ovr_en = 1'b0;
    check("jst_opcode", 32'(bus.opcode), 32'd2);
    check("jst_pc",     bus.imem_addr, 32'h14);
    bus.ex_mem2reg = 1'b1; bus.ex_rt = 5'd5;
    #1;
    check("jst_stall", 32'(bus.Stall), 32'd1);
    step();
    check("jst_pc_held", bus.imem_addr, 32'h14);
    check("jst_cnt2",    32'(bus.stall_cnt), 32'd2);
    step();
    check("jst_cnt3",    32'(bus.stall_cnt), 32'd3);
    step();
    check("jst_cnt_sat", 32'(bus.stall_cnt), 32'd3);
    check("jst_pc_held2", bus.imem_addr, 32'h14);

    // Branch beats stall and jump
    bus.br_taken = 1'b1; bus.br_target = 32'h80;
    #1;
    check("br_stall", 32'(bus.Stall), 32'd0);
    check("br_flush", 32'(bus.flush_id), 32'd1);
    step();
    check("br_pc",     bus.imem_addr, 32'h80);
    check("br_valid",  32'(bus.id_valid), 32'd0);
    check("br_opcode", 32'(bus.opcode), 32'd0);
    check("br_state",  32'(bus.fsm_state), 32'd2);
    bus.ex_mem2reg = 1'b0; bus.ex_rt = 5'd0;

    // Branch to 0x1000_0004 to place j 0x40 at pc_plus4=0x1000_0008
    bus.br_target = 32'h1000_0004;
    step();
    bus.br_taken = 1'b0;
    #1;
    check("br2_flush_off", 32'(bus.flush_id), 32'd0);
    check("br2_pc", bus.imem_addr, 32'h1000_0004);
    ovr_en = 1'b1; ovr_word = 32'h0800_0040;
    step();
    ovr_en = 1'b0;
    check("j_pp4",   bus.pc_plus4, 32'h1000_0008);
    check("j_state", 32'(bus.fsm_state), 32'd1);
    step();
    check("j_pc",     bus.imem_addr, 32'h1000_0100);
    check("j_valid",  32'(bus.id_valid), 32'd0);
    check("j_funct",  32'(bus.funct), 32'd0);
    check("j_state2", 32'(bus.fsm_state), 32'd2);
    step();
    check("j_after_pc",  bus.imem_addr, 32'h1000_0104);
    check("j_after_opc", 32'(bus.opcode), 32'hC);
    check("j_after_imm", 32'(bus.imm), 32'h0100);
    check("j_after_st",  32'(bus.fsm_state), 32'd1);

    // PC wrap
    bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
    step();
    bus.br_taken = 1'b0;
    check("wrap_pc0", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc",  bus.imem_addr, 32'h0);
    check("wrap_pp4", bus.pc_plus4, 32'h0);
    check("wrap_imm", 32'(bus.imm), 32'hFFFC);

    // Reset during FLUSH
    bus.br_taken = 1'b1; bus.br_target = 32'h200;
    step();
    check("fl_state", 32'(bus.fsm_state), 32'd2);
    rst = 1'b1;
    #1;
    check("fl_rst_flush", 32'(bus.flush_id), 32'd0);
    step();
    bus.br_taken = 1'b0;
    check("fl_rst_pc",    bus.imem_addr, 32'h0);
    check("fl_rst_valid", 32'(bus.id_valid), 32'd0);
    check("fl_rst_cnt",   32'(bus.stall_cnt), 32'd0);
    check("fl_rst_state", 32'(bus.fsm_state), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_pc", bus.imem_addr, 32'h4);
    check("post_rst_st", 32'(bus.fsm_state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
